// File: rtl/mem_load_unit.sv
// Load path of the MEM stage: issues one data-bus read per load and
// returns the aligned, sign/zero-extended result to the pipeline.
module mem_load_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_type,
  input  logic        req_signed,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] rdata,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_addr;
  logic [1:0]  r_type;
  logic        r_signed;
  logic [31:0] r_rdata;
  logic        r_addr_err;

  logic        w_misalign;
  logic        w_accept;
  logic        w_reject;
  logic        w_capture;
  logic [31:0] w_ext;

  function automatic logic [31:0] f_extract(
    input logic [1:0]  t,
    input logic [1:0]  ty,
    input logic        sg,
    input logic [31:0] d
  );
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] res;
    h = t[1] ? d[31:16] : d[15:0];
    case (t)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    unique case (1'b1)
      (ty == 2'b00): res = d;
      (ty == 2'b01): res = {{16{sg & h[15]}}, h};
      default:       res = {{24{sg & b[7]}}, b};
    endcase
    return res;
  endfunction

  // Bytes are always aligned; types 10 and 11 both mean byte.
  always_comb begin
    w_misalign = 1'b0;
    unique case (1'b1)
      (req_type == 2'b00): w_misalign = |req_addr[1:0];
      (req_type == 2'b01): w_misalign = req_addr[0];
      default:             w_misalign = 1'b0;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) & req_valid & ~w_misalign;
  assign w_reject = (r_state == S_IDLE) & req_valid &  w_misalign;

  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_REQ;
      end
      S_REQ: begin
        if (dresp_addr_ok & dresp_data_ok) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end else if (dresp_addr_ok) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dresp_data_ok) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  assign w_ext = f_extract(r_addr[1:0], r_type,
                           r_signed, dresp_data);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= '0;
      r_type     <= '0;
      r_signed   <= 1'b0;
      r_rdata    <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= w_reject;
      if (w_accept) begin
        r_addr   <= req_addr;
        r_type   <= req_type;
        r_signed <= req_signed;
      end
      if (w_capture) r_rdata <= w_ext;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign dreq_valid = (r_state == S_REQ);
  assign dreq_addr  = {r_addr[31:2], 2'b00};
  assign dreq_size  = (r_type == 2'b11) ? 2'b10 : r_type;
  assign resp_valid = (r_state == S_DONE);
  assign rdata      = r_rdata;
  assign addr_err   = r_addr_err;

endmodule
